addr_unpack_fifo: RTL and testbench

Parametrised address queue: successor to the fixed 3-entry address stack machine. Unpacks one or two tagged addresses from each input word and queues them in a DEPTH-entry circular buffer. Adds explicit pop, occupancy count, space-aware backpressure and sticky error flags. Sits between the instruction/operand fetch stage and the memory-address consumer.

---
 rtl/addr_fifo_pkg.sv | 16 +
 rtl/addr_unpack_fifo_if.sv | 17 +
 rtl/addr_unpack.sv | 19 +
 rtl/addr_unpack_fifo.sv | 57 +++++
 tb/tb_addr_unpack_fifo.sv | 114 +++++++++++
 5 files changed

// File: rtl/addr_fifo_pkg.sv
// addr_fifo_pkg: push command encodings, entry-need constants and default sizes for the address queue
package addr_fifo_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_TAG_WIDTH = 4;
  localparam int DEF_DEPTH = 4;
  localparam logic [1:0] CTL_NOP = 2'b00;
  localparam logic [1:0] CTL_PUSH_LO = 2'b01;
  localparam logic [1:0] CTL_PUSH_HI = 2'b10;
  localparam logic [1:0] CTL_PUSH_PAIR = 2'b11;
  localparam logic [1:0] NEED_NOP = 2'd0;
  localparam logic [1:0] NEED_ONE = 2'd1;
  localparam logic [1:0] NEED_PAIR = 2'd2;
  function automatic logic [1:0] need_of(input logic [1:0] ctl);
    return ctl == CTL_PUSH_PAIR ? NEED_PAIR : ctl == CTL_NOP ? NEED_NOP : NEED_ONE;
  endfunction
endpackage

// File: rtl/addr_unpack_fifo_if.sv
// addr_unpack_fifo_if: producer/consumer bus of the address queue
interface addr_unpack_fifo_if import addr_fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  logic [1:0] ctl;
  logic i_pop;
  logic [DATA_WIDTH-1:0] DATA_in;
  logic [DATA_WIDTH-1:0] DATA_out;
  logic o_valid;
  logic o_wait;
  logic [$clog2(DEPTH+1)-1:0] o_count;
  logic o_overflow;
  logic o_underflow;
  modport master(output ctl, i_pop, DATA_in, input DATA_out, o_valid, o_wait, o_count, o_overflow, o_underflow);
  modport slave(input ctl, i_pop, DATA_in, output DATA_out, o_valid, o_wait, o_count, o_overflow, o_underflow);
endinterface

// File: rtl/addr_unpack.sv
// addr_unpack: splits a tagged word into tag-prefixed LO and HI addresses
module addr_unpack #(
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] lo,
  output logic [DATA_WIDTH-1:0] hi
);
  localparam int H = DATA_WIDTH / 2;
  always_comb begin
    lo = '0;
    hi = '0;
    lo[H-1:0] = data[H-1:0];
    hi[H-1:0] = data[DATA_WIDTH-1:H];
    lo[DATA_WIDTH-1:DATA_WIDTH-TAG_WIDTH] = data[DATA_WIDTH-1:DATA_WIDTH-TAG_WIDTH];
    hi[DATA_WIDTH-1:DATA_WIDTH-TAG_WIDTH] = data[DATA_WIDTH-1:DATA_WIDTH-TAG_WIDTH];
  end
endmodule

// File: rtl/addr_unpack_fifo.sv
// addr_unpack_fifo: circular queue of unpacked addresses with all-or-nothing pushes and sticky error flags
module addr_unpack_fifo import addr_fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TAG_WIDTH = DEF_TAG_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic clk,
  input logic rst,
  addr_unpack_fifo_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, wr_nxt;
  logic [CW-1:0] count;
  logic [CW:0] free;
  logic [DATA_WIDTH-1:0] lo, hi;
  logic [1:0] need;
  logic pop_ok, push_ok, ovf, unf;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  addr_unpack #(.DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(TAG_WIDTH)) u_unpack (.data(bus.DATA_in), .lo(lo), .hi(hi));
  always_comb begin
    need = need_of(bus.ctl);
    pop_ok = bus.i_pop && count != '0;
    free = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(pop_ok);
    push_ok = need != NEED_NOP && (CW+1)'(need) <= free;
    wr_nxt = inc(wr_ptr);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (pop_ok) rd_ptr <= inc(rd_ptr);
      if (push_ok) wr_ptr <= need == NEED_PAIR ? inc(wr_nxt) : wr_nxt;
      count <= count + CW'(push_ok ? need : NEED_NOP) - CW'(pop_ok);
      if (need != NEED_NOP && !push_ok) ovf <= 1'b1;
      if (bus.i_pop && count == '0) unf <= 1'b1;
    end
  end
  // Storage is not reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.ctl == CTL_PUSH_HI ? hi : lo;
    if (push_ok && need == NEED_PAIR) mem[wr_nxt] <= hi;
  end
  assign bus.DATA_out = count != '0 ? mem[rd_ptr] : '0;
  assign bus.o_valid = count != '0;
  assign bus.o_wait = count > CW'(DEPTH - 2);
  assign bus.o_count = count;
  assign bus.o_overflow = ovf;
  assign bus.o_underflow = unf;
endmodule

// File: tb/tb_addr_unpack_fifo.sv
// tb_addr_unpack_fifo: directed scenarios for the address queue with hand-computed expectations
module tb_addr_unpack_fifo;
  import addr_fifo_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  addr_unpack_fifo_if #(.DATA_WIDTH(16), .DEPTH(4)) bus ();
  addr_unpack_fifo #(.DATA_WIDTH(16), .TAG_WIDTH(4), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step(input logic [1:0] c, input logic p, input logic [15:0] d);
    bus.ctl = c;
    bus.i_pop = p;
    bus.DATA_in = d;
    @(posedge clk);
    #1;
    bus.ctl = CTL_NOP;
    bus.i_pop = 1'b0;
    bus.DATA_in = '0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_reset();
    bus.ctl = CTL_NOP;
    bus.i_pop = 1'b0;
    bus.DATA_in = '0;
    do_reset();
    tests++; if (bus.DATA_out !== 16'h0) begin fails++; $display("FAIL reset_data got %h want 0000", bus.DATA_out); end
    tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bus.o_valid); end
    tests++; if (bus.o_wait !== 1'b0) begin fails++; $display("FAIL reset_wait got %b want 0", bus.o_wait); end
    tests++; if (bus.o_count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", bus.o_count); end
    tests++; if ({bus.o_overflow, bus.o_underflow} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b want 00", {bus.o_overflow, bus.o_underflow}); end
  endtask
  task automatic test_pair();
    step(CTL_PUSH_PAIR, 1'b0, 16'hA35C);
    tests++; if (bus.DATA_out !== 16'hA05C) begin fails++; $display("FAIL pair_lo got %h want a05c", bus.DATA_out); end
    tests++; if (bus.o_count !== 3'd2) begin fails++; $display("FAIL pair_count got %0d want 2", bus.o_count); end
    step(CTL_NOP, 1'b1, 16'h0);
    tests++; if (bus.DATA_out !== 16'hA0A3) begin fails++; $display("FAIL pair_hi got %h want a0a3", bus.DATA_out); end
    step(CTL_NOP, 1'b1, 16'h0);
    tests++; if ({bus.o_valid, bus.DATA_out} !== 17'h0) begin fails++; $display("FAIL pair_empty got valid=%b data=%h want 0 0000", bus.o_valid, bus.DATA_out); end
  endtask
  task automatic test_overflow();
    do_reset();
    step(CTL_PUSH_LO, 1'b0, 16'h5001);
    step(CTL_PUSH_LO, 1'b0, 16'h5002);
    step(CTL_PUSH_LO, 1'b0, 16'h5003);
    tests++; if ({bus.o_count, bus.o_wait} !== {3'd3, 1'b1}) begin fails++; $display("FAIL three_count_wait got %0d %b want 3 1", bus.o_count, bus.o_wait); end
    step(CTL_PUSH_PAIR, 1'b0, 16'h1234);
    tests++; if ({bus.o_count, bus.o_overflow} !== {3'd3, 1'b1}) begin fails++; $display("FAIL pair_drop got count=%0d ovf=%b want 3 1", bus.o_count, bus.o_overflow); end
    step(CTL_PUSH_LO, 1'b0, 16'h1234);
    tests++; if ({bus.o_count, bus.DATA_out} !== {3'd4, 16'h5001}) begin fails++; $display("FAIL lo_fill got count=%0d head=%h want 4 5001", bus.o_count, bus.DATA_out); end
  endtask
  task automatic test_full_pop();
    do_reset();
    step(CTL_PUSH_LO, 1'b0, 16'h6001);
    step(CTL_PUSH_LO, 1'b0, 16'h6002);
    step(CTL_PUSH_LO, 1'b0, 16'h6003);
    step(CTL_PUSH_LO, 1'b0, 16'h6004);
    step(CTL_PUSH_PAIR, 1'b1, 16'h7788);
    tests++; if ({bus.o_count, bus.o_overflow, bus.DATA_out} !== {3'd3, 1'b1, 16'h6002}) begin fails++; $display("FAIL full_pair_pop got count=%0d ovf=%b head=%h want 3 1 6002", bus.o_count, bus.o_overflow, bus.DATA_out); end
    step(CTL_PUSH_LO, 1'b1, 16'h7788);
    step(CTL_PUSH_LO, 1'b0, 16'h8899);
    tests++; if ({bus.o_count, bus.DATA_out} !== {3'd4, 16'h6003}) begin fails++; $display("FAIL refill got count=%0d head=%h want 4 6003", bus.o_count, bus.DATA_out); end
    step(CTL_PUSH_LO, 1'b1, 16'hAB12);
    tests++; if ({bus.o_count, bus.DATA_out} !== {3'd4, 16'h6004}) begin fails++; $display("FAIL full_lo_pop got count=%0d head=%h want 4 6004", bus.o_count, bus.DATA_out); end
    step(CTL_NOP, 1'b1, 16'h0);
    tests++; if (bus.DATA_out !== 16'h7088) begin fails++; $display("FAIL drain0 got %h want 7088", bus.DATA_out); end
    step(CTL_NOP, 1'b1, 16'h0);
    tests++; if (bus.DATA_out !== 16'h8099) begin fails++; $display("FAIL drain1 got %h want 8099", bus.DATA_out); end
    step(CTL_NOP, 1'b1, 16'h0);
    tests++; if ({bus.o_count, bus.DATA_out} !== {3'd1, 16'hA012}) begin fails++; $display("FAIL drain2 got count=%0d head=%h want 1 a012", bus.o_count, bus.DATA_out); end
  endtask
  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 3; i++) step(CTL_PUSH_LO, 1'b0, 16'h0011);
    for (int i = 0; i < 3; i++) step(CTL_NOP, 1'b1, 16'h0);
    step(CTL_PUSH_PAIR, 1'b0, 16'hB7E1);
    tests++; if ({bus.o_count, bus.DATA_out} !== {3'd2, 16'hB0E1}) begin fails++; $display("FAIL wrap_lo got count=%0d head=%h want 2 b0e1", bus.o_count, bus.DATA_out); end
    step(CTL_NOP, 1'b1, 16'h0);
    tests++; if (bus.DATA_out !== 16'hB0B7) begin fails++; $display("FAIL wrap_hi got %h want b0b7", bus.DATA_out); end
    step(CTL_NOP, 1'b1, 16'h0);
    tests++; if ({bus.o_valid, bus.o_underflow} !== 2'b00) begin fails++; $display("FAIL wrap_empty got valid=%b unf=%b want 0 0", bus.o_valid, bus.o_underflow); end
  endtask
  task automatic test_underflow_and_async_reset();
    do_reset();
    step(CTL_PUSH_HI, 1'b1, 16'hC4D2);
    tests++; if ({bus.o_underflow, bus.o_overflow, bus.o_count, bus.DATA_out} !== {2'b10, 3'd1, 16'hC0C4}) begin fails++; $display("FAIL underflow_push got unf=%b ovf=%b count=%0d head=%h want 1 0 1 c0c4", bus.o_underflow, bus.o_overflow, bus.o_count, bus.DATA_out); end
    step(CTL_PUSH_LO, 1'b0, 16'h0101);
    step(CTL_PUSH_LO, 1'b0, 16'h0202);
    step(CTL_PUSH_PAIR, 1'b0, 16'h0303);
    tests++; if ({bus.o_count, bus.o_overflow, bus.o_wait} !== {3'd3, 1'b1, 1'b1}) begin fails++; $display("FAIL pre_reset got count=%0d ovf=%b wait=%b want 3 1 1", bus.o_count, bus.o_overflow, bus.o_wait); end
    #2 rst = 1'b1;
    #1;
    tests++; if ({bus.DATA_out, bus.o_valid, bus.o_wait, bus.o_count, bus.o_overflow, bus.o_underflow} !== 23'h0) begin fails++; $display("FAIL async_reset got data=%h v=%b w=%b c=%0d ovf=%b unf=%b want all 0", bus.DATA_out, bus.o_valid, bus.o_wait, bus.o_count, bus.o_overflow, bus.o_underflow); end
    #2 rst = 1'b0;
    step(CTL_PUSH_LO, 1'b0, 16'h9001);
    tests++; if ({bus.o_count, bus.DATA_out} !== {3'd1, 16'h9001}) begin fails++; $display("FAIL post_reset got count=%0d head=%h want 1 9001", bus.o_count, bus.DATA_out); end
  endtask
  initial begin
    test_reset();
    test_pair();
    test_overflow();
    test_full_pop();
    test_wrap();
    test_underflow_and_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
